single_port_ram_arbiter: RTL and testbench
==========================================

Name: single_port_ram_arbiter

Overview:
- Two-requester arbiter that shares one single_port_ram instance (write when en=1, registered read when en=0).
- Accepts read/write requests over a valid/ready handshake and serialises them onto the RAM port.
- Returns one response pulse per request (read data or write acknowledge).
- Sits between two client engines and the RAM; the RAM is instantiated outside this block.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width (depth 2**ADDR_WIDTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request pending from requester 0 / 1.
- req0_we / req1_we  in  1  1=write, 0=read.
- req0_addr / req1_addr  in  ADDR_WIDTH  target address.
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data.
- req0_ready / req1_ready  out  1  combinational grant; handshake completes when valid&&ready.
- resp0_valid / resp1_valid  out  1  one-cycle response pulse.
- resp0_rdata / resp1_rdata  out  DATA_WIDTH  read data; valid only with a read response.
- ram_en  out  1  to RAM en (write strobe).
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM data_in.
- ram_rdata  in  DATA_WIDTH  from RAM data.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: state=IDLE, ram_en=0, ram_addr=0, ram_wdata=0, resp*_valid=0, resp*_rdata=0, last_grant=1 (requester 0 wins first).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is computed combinationally; ready is asserted only for the winner and only in IDLE.
  - One valid: that requester wins.
  - Both valid: the requester != last_grant wins (round-robin).
  - On the accept edge: register ram_addr and ram_wdata from the winner, ram_en <= winner we, latch the id, last_grant <= id, go to ACCESS.
- ACCESS:
  - The RAM sees the registered ram_en/ram_addr/ram_wdata this cycle and acts on its closing edge.
  - On exit: ram_en <= 0 and ram_addr is held.
  - Write: pulse resp<id>_valid next cycle (rdata unchanged); go to IDLE.
  - Read: go to RESP.
- RESP:
  - ram_addr is held.
  - On the closing edge: resp<id>_rdata <= ram_rdata, resp<id>_valid <= 1, go to IDLE.
- resp*_valid is high for exactly one cycle per accepted request; the other requester's outputs are unchanged.
- Latency, counted from accept edge T:
  - Write is committed at edge T+1; resp_valid is high in cycle T+1..T+2.
  - Read: resp_valid and rdata are high in cycle T+2..T+3.
- Throughput: back-to-back writes are accepted every 2 cycles, reads every 3 cycles. A new request may be accepted in the same cycle a response pulse is visible.
- ram_en is never high for more than one cycle per write; it is never high outside ACCESS.
- A requester must hold valid, we, addr and wdata stable until ready. Dropping valid before ready withdraws the request without side effects.
- Same-address read after write from either requester returns the new data.
- Reset mid-operation:
  - All registers return to reset values at the reset edge; no pending response is issued.
  - A write whose ACCESS cycle coincides with the reset edge is still committed by the RAM, which has no reset. This is defined behaviour.
- Address and data pass through unmodified; there is no address wrap logic (the RAM index is natural width).

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins simultaneous requests; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset, then req0 write addr=3 wdata=0xA5 -> req0_ready in accept cycle; ram_en=1, addr=3 for exactly 1 cycle; resp0_valid pulse 2 cycles after accept.
- req1 read addr=3 after the above -> resp1_valid with resp1_rdata=0xA5, 3 cycles after accept; resp0_valid stays 0.
- Both requesters hold valid continuously (r0: write addr=0..3; r1: read addr=0..3) -> grants alternate 0,1,0,1 starting with 0; with ARB_FIXED_PRIORITY_EN all four r0 grants come first.
- Write addr=15 wdata=0xFF, then read addr=15 -> 0xFF (top-of-range address); read addr=0 after reset writes returns the written value.
- rst asserted in the ACCESS cycle of a read -> no resp pulse; busy=0 and all outputs at reset values the next cycle; a subsequent read completes normally.
- req0_valid pulsed for one cycle while the arbiter is busy -> never granted; no RAM access and no response for it.

Source files
------------

// File: rtl/single_port_ram_arbiter.sv
// Two-requester valid/ready arbiter serialising reads and writes onto one external single-port RAM.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 win simultaneous requests (default: round-robin).
module single_port_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  id_q, id_d;
  logic                  ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  resp0_valid_q, resp0_valid_d;
  logic                  resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0] resp0_rdata_q, resp0_rdata_d;
  logic [DATA_WIDTH-1:0] resp1_rdata_q, resp1_rdata_d;
  logic                  gnt0, gnt1;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
    end
  end
`else
  // last_grant_q == 1 means requester 0 has priority on the next tie.
  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0 || gnt1) begin
      last_grant_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    ram_en_d      = ram_en_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_rdata_d = resp0_rdata_q;
    resp1_rdata_d = resp1_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d        = gnt1;
          ram_en_d    = gnt1 ? req1_we    : req0_we;
          ram_addr_d  = gnt1 ? req1_addr  : req0_addr;
          ram_wdata_d = gnt1 ? req1_wdata : req0_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM commits a write (or captures read data) on the edge closing this cycle.
        ram_en_d = 1'b0;
        if (ram_en_q) begin
          resp0_valid_d = !id_q;
          resp1_valid_d = id_q;
          state_d       = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (id_q) begin
          resp1_valid_d = 1'b1;
          resp1_rdata_d = ram_rdata;
        end else begin
          resp0_valid_d = 1'b1;
          resp0_rdata_d = ram_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      ram_en_q      <= ram_en_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: external RAM model, timestamp-based transaction model, directed and random stimulus.
`timescale 1ns/1ps
module tb_single_port_ram_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy;

  single_port_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_rdata(resp0_rdata), .resp1_rdata(resp1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // External single-port RAM: write when en=1, registered read otherwise; no reset.
  logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) ram_mem[ram_addr] <= ram_wdata;
    else        ram_rdata <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Transaction model: everything is expressed as "the cycle in which X is visible".
  logic [DW-1:0] mm [DEPTH] = '{default: '0};
  int            idle_at = 0;
  bit            lg = 1'b1;
  int            en_cyc = -1;
  int            rv_cyc [2] = '{-1, -1};
  bit            rv_rd [2] = '{1'b0, 1'b0};
  logic [DW-1:0] rv_data [2] = '{'0, '0};
  logic [DW-1:0] cur_rd [2] = '{'0, '0};
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  int            gq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_step();
    bit            idle;
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    idle = (cyc >= idle_at);
    w = -1;
    if (idle) begin
      if (req0_valid && req1_valid) w = (FIXED || lg) ? 0 : 1;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    for (int i = 0; i < 2; i++) if (rv_cyc[i] == cyc && rv_rd[i]) cur_rd[i] = rv_data[i];
    chk("ready0", 32'(req0_ready), 32'(w == 0));
    chk("ready1", 32'(req1_ready), 32'(w == 1));
    chk("busy", 32'(busy), 32'(!idle));
    chk("ram_en", 32'(ram_en), 32'(en_cyc == cyc));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    chk("resp0_valid", 32'(resp0_valid), 32'(rv_cyc[0] == cyc));
    chk("resp1_valid", 32'(resp1_valid), 32'(rv_cyc[1] == cyc));
    chk("resp0_rdata", 32'(resp0_rdata), 32'(cur_rd[0]));
    chk("resp1_rdata", 32'(resp1_rdata), 32'(cur_rd[1]));
    if (rst) begin
      idle_at = 0; lg = 1'b1; en_cyc = -1;
      rv_cyc[0] = -1; rv_cyc[1] = -1;
      cur_rd[0] = '0; cur_rd[1] = '0;
      e_addr = '0; e_wdata = '0;
    end else if (w >= 0) begin
      a  = (w == 1) ? req1_addr  : req0_addr;
      d  = (w == 1) ? req1_wdata : req0_wdata;
      we = (w == 1) ? req1_we    : req0_we;
      e_addr = a; e_wdata = d; lg = (w == 1);
      if (we) begin
        mm[a] = d; en_cyc = cyc + 1; rv_cyc[w] = cyc + 2; rv_rd[w] = 1'b0; idle_at = cyc + 2;
      end else begin
        rv_data[w] = mm[a]; rv_cyc[w] = cyc + 3; rv_rd[w] = 1'b1; idle_at = cyc + 3;
      end
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input int id, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
    else         begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
  endtask

  // Holds the current request until it is accepted; returns just after the accept edge.
  task automatic wait_acc(input int id);
    bit got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (rdy(id) && !rst) begin
        got = 1'b1;
        @(posedge clk); #1;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    else      gq.push_back(id);
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_driver(input int id, input int ncyc);
    int            t = 0;
    int            patience;
    bit            done;
    logic          we;
    logic [AW-1:0] a;
    while (t < ncyc) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; t++; end
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      set_req(id, 1'b1, we, a, DW'($urandom));
      patience = $urandom_range(1, 8);
      done = 1'b0;
      for (int k = 0; k < patience && !done; k++) begin
        @(negedge clk);
        if (rdy(id) && !rst) done = 1'b1;
        @(posedge clk); #1; t++;
      end
      set_req(id, 1'b0, 1'b0, '0, '0);
    end
  endtask

  int exp_order [8];

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    fork
      forever begin @(negedge clk); model_step(); end
    join_none
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_resp1_rdata", 32'(resp1_rdata), 32'd0);

    // Write r0 addr 3 = A5.
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_ram_en", 32'(ram_en), 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'd3);
    chk("t1_ram_wdata", 32'(ram_wdata), 32'hA5);
    @(negedge clk);
    chk("t1_ram_en_off", 32'(ram_en), 32'd0);
    chk("t1_resp0", 32'(resp0_valid), 32'd1);
    @(negedge clk);
    chk("t1_resp0_off", 32'(resp0_valid), 32'd0);

    // Read r1 addr 3.
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 4'd3, 8'h00);
    wait_acc(1);
    @(negedge clk);
    chk("t2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2_resp1_early", 32'(resp1_valid), 32'd0);
    @(negedge clk);
    chk("t2_resp1", 32'(resp1_valid), 32'd1);
    chk("t2_rdata", 32'(resp1_rdata), 32'hA5);
    chk("t2_resp0", 32'(resp0_valid), 32'd0);

    // Both requesters hold valid continuously.
    @(posedge clk); #1;
    gq.delete();
    fork
      for (int i = 0; i < 4; i++) begin set_req(0, 1'b1, 1'b1, AW'(i), DW'(8'h10 + i)); wait_acc(0); end
      for (int i = 0; i < 4; i++) begin set_req(1, 1'b1, 1'b0, AW'(i), 8'h00); wait_acc(1); end
    join
    exp_order = FIXED ? '{0, 0, 0, 0, 1, 1, 1, 1} : '{0, 1, 0, 1, 0, 1, 0, 1};
    chk("t3_grants", 32'(gq.size()), 32'd8);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("t3_order", 32'(gq[i]), 32'(exp_order[i]));
    repeat (4) @(posedge clk); #1;

    // Top-of-range address, then addr 0 written above.
    set_req(0, 1'b1, 1'b1, 4'd15, 8'hFF); wait_acc(0);
    set_req(0, 1'b1, 1'b0, 4'd15, 8'h00); wait_acc(0);
    repeat (3) @(negedge clk);
    chk("t4_resp0", 32'(resp0_valid), 32'd1);
    chk("t4_rdata15", 32'(resp0_rdata), 32'hFF);
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 4'd0, 8'h00); wait_acc(1);
    repeat (3) @(negedge clk);
    chk("t4_rdata0", 32'(resp1_rdata), 32'h10);

    // Reset during the ACCESS cycle of a read.
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 4'd15, 8'h00); wait_acc(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_access", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ram_addr", 32'(ram_addr), 32'd0);
    chk("t5_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("t5_resp1", 32'(resp1_valid), 32'd0);
    chk("t5_rdata0", 32'(resp0_rdata), 32'd0);
    @(negedge clk);
    chk("t5_resp1_late", 32'(resp1_valid), 32'd0);
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 4'd15, 8'h00); wait_acc(1);
    repeat (3) @(negedge clk);
    chk("t5_resp1_again", 32'(resp1_valid), 32'd1);
    chk("t5_rdata_again", 32'(resp1_rdata), 32'hFF);

    // A one-cycle req0 pulse while busy must vanish without effect.
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 4'd2, 8'h00); wait_acc(1);
    set_req(0, 1'b1, 1'b1, 4'd5, 8'h5A);
    @(negedge clk);
    chk("t6_ready0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_resp0", 32'(resp0_valid), 32'd0);
      chk("t6_no_addr5", 32'(ram_addr == 4'd5), 32'd0);
    end

    // Randomised traffic with occasional resets.
    @(posedge clk); #1;
    fork
      rand_driver(0, 3000);
      rand_driver(1, 3000);
      for (int k = 0; k < 3000; k++) begin
        @(posedge clk); #1;
        rst = ($urandom_range(0, 149) == 0);
      end
    join
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
